// File: rtl/life_matrix_scan.sv
// life_matrix_scan: double-buffered 8x8 Life frame scanner driving an active-low row / column LED matrix
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   enable            scan permission, sampled in IDLE and at frame end
//   grid, grid_valid  offered frame (row r = grid[63-8r -: 8], msb = column 0)
//   grid_ready        pending buffer empty
//   row_n, col        active-low one-hot row drive and column data of the lit row
//   frame_done        one-cycle pulse after row 7 finishes
//   live_count        population of the frame in the display buffer
module life_matrix_scan #(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic [7:0]  row_n,
  output logic [7:0]  col,
  output logic        frame_done,
  output logic [6:0]  live_count
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_SHOW} state_t;
  state_t state, nxt;
  logic [63:0] pending, display;
  logic        pending_full;
  logic [2:0]  r;
  logic [15:0] cnt;
  logic [6:0]  pop;
  logic        show_end;
  assign grid_ready = ~pending_full;
  always_comb begin
    pop = '0;
    for (int i = 0; i < 64; i++) pop = pop + 7'(pending[i]);
  end
  // row r occupies bits 63-8r down to 56-8r, i.e. top index {~r, 3'b111}
  always_comb begin
    show_end = cnt == 16'(DWELL - 1);
    nxt = state;
    row_n = 8'hFF;
    col = '0;
    case (state)
      S_IDLE:  nxt = enable && pending_full ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_BLANK;
      S_BLANK: nxt = cnt == 16'(BLANK - 1) ? S_SHOW : S_BLANK;
      S_SHOW: begin
        row_n = ~(8'd1 << r);
        col = display[{~r, 3'b111} -: 8];
        if (show_end)
          nxt = r != 3'd7 ? S_BLANK : enable && pending_full ? S_LOAD : enable ? S_BLANK : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end
  // cnt restarts on every state change, so it always counts cycles spent in the current state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      r <= '0;
      pending <= '0;
      pending_full <= 1'b0;
      display <= '0;
      live_count <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt == state ? cnt + 16'd1 : '0;
      frame_done <= state == S_SHOW && show_end && r == 3'd7;
      if (state == S_LOAD) begin
        display <= pending;
        pending_full <= 1'b0;
        live_count <= pop;
        r <= '0;
      end else if (grid_valid && !pending_full) begin
        pending <= grid;
        pending_full <= 1'b1;
      end
      if (state == S_SHOW && show_end) r <= r + 3'd1;
    end
  end
endmodule

// File: tb/tb_life_matrix_scan.sv
// tb_life_matrix_scan: scoreboard bench for life_matrix_scan with DWELL=3, BLANK=2
module tb_life_matrix_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] grid = '0;
  logic        grid_valid = 1'b0;
  logic        grid_ready;
  logic [7:0]  row_n, col;
  logic        frame_done;
  logic [6:0]  live_count;
  typedef struct packed {logic [7:0] rn; logic [7:0] c; logic [6:0] lc;} exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0, run = 0, k;
  logic sb_on = 1'b1;
  logic [7:0] prev_rn = 8'hFF, prev_col = '0;
  localparam logic [63:0] FA = 64'h2222_2200_0077_0000;
  localparam logic [63:0] FB = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FC = 64'h8142_2418_1824_4281;
  localparam logic [63:0] FD = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] FE = 64'h1234_5678_9ABC_DEF0;
  life_matrix_scan #(.DWELL(3), .BLANK(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .grid(grid), .grid_valid(grid_valid),
    .grid_ready(grid_ready), .row_n(row_n), .col(col), .frame_done(frame_done), .live_count(live_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic push_frame(input logic [63:0] g);
    exp_t x;
    for (int r = 0; r < 8; r++) begin
      x.rn = ~(8'd1 << r);
      x.c = g[63-8*r -: 8];
      x.lc = 7'($countones(g));
      sb.push_back(x);
    end
  endtask
  task automatic wait_row(input logic [7:0] rn, input string tag);
    int n = 0;
    while (row_n != rn && n < 300) begin tick; n++; end
    check(tag, row_n, rn);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 300) begin tick; n++; end
    check(tag, frame_done, 1);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      prev_rn = 8'hFF;
      prev_col = '0;
      run = 0;
    end else begin
      check("onehot", $countones(~row_n) <= 1, 1);
      check("frame_done_timing", frame_done, prev_rn == 8'h7F && row_n == 8'hFF);
      if (row_n == 8'hFF) begin
        check("blank_col", col, 0);
        if (prev_rn != 8'hFF) check("dwell_len", run, 3);
      end else if (prev_rn == 8'hFF) begin
        run = 1;
        if (sb_on) begin
          if (sb.size() != 0) e = sb.pop_front();
          else e = '0;
          check("sb_row", row_n, e.rn);
          check("sb_col", col, e.c);
          check("sb_live", live_count, e.lc);
        end
      end else begin
        run++;
        check("row_hold", row_n, prev_rn);
        check("col_hold", col, prev_col);
      end
      prev_rn = row_n;
      prev_col = col;
    end
  end
  initial begin
    repeat (3) tick;
    check("rst_ready", grid_ready, 1);
    check("rst_row_n", row_n, 8'hFF);
    check("rst_col", col, 0);
    check("rst_live", live_count, 0);
    check("rst_done", frame_done, 0);
    reset = 1'b1;
    enable = 1'b1;
    grid = FA;
    grid_valid = 1'b1;
    push_frame(FA);
    tick;
    check("a_accept", grid_ready, 0);
    check("a_idle", row_n, 8'hFF);
    grid_valid = 1'b0;
    repeat (3) tick;
    check("a_e3_dark", row_n, 8'hFF);
    tick;
    check("a_e4_row", row_n, 8'hFE);
    check("a_e4_col", col, 8'h22);
    check("a_e4_live", live_count, 12);
    k = 4;
    while (!frame_done && k < 200) begin
      tick;
      k++;
      if (k == 12) begin grid = FB; grid_valid = 1'b1; push_frame(FB); end
      if (k == 13) begin check("b_ready_drop", grid_ready, 0); grid = FC; push_frame(FC); end
    end
    check("a_done_latency", k, 42);
    check("c_stalled", grid_ready, 0);
    k = 0;
    while (!grid_ready && k < 50) begin tick; k++; end
    check("c_ready_after_load", grid_ready, 1);
    tick;
    grid_valid = 1'b0;
    check("c_accept", grid_ready, 0);
    wait_done("b_done");
    tick;
    wait_row(8'hF7, "c_row3");
    enable = 1'b0;
    tick;
    wait_done("c_done");
    repeat (5) tick;
    check("c_idle_row", row_n, 8'hFF);
    check("c_idle_ready", grid_ready, 1);
    check("sb_drained", sb.size(), 0);
    sb_on = 1'b0;
    enable = 1'b1;
    grid = FD;
    grid_valid = 1'b1;
    tick;
    grid_valid = 1'b0;
    repeat (3) tick;
    grid = FE;
    grid_valid = 1'b1;
    tick;
    grid_valid = 1'b0;
    check("e_pending", grid_ready, 0);
    wait_row(8'hDF, "d_row5");
    reset = 1'b0;
    tick;
    check("mid_rst_row", row_n, 8'hFF);
    check("mid_rst_col", col, 0);
    check("mid_rst_ready", grid_ready, 1);
    check("mid_rst_live", live_count, 0);
    check("mid_rst_done", frame_done, 0);
    reset = 1'b1;
    repeat (6) tick;
    check("post_rst_dark", row_n, 8'hFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
